// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// The CHECK state exists only when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
package instruction_loader_pkg;

    localparam int BYTES_PER_WORD    = 4;
    localparam int WORD_W            = 32;
    localparam int DEFAULT_MEM_DEPTH = 100;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;
`endif

    // A session length is usable when it names at least one word and fits the memory.
    function automatic logic len_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Byte-to-word packer: big-endian, first byte lands in [31:24].
// Latency: word and word_full are combinational with the fourth byte; never stalls.
// Backpressure: none, the caller only gates byte_en.
module loader_word_pack
    import instruction_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    // Only the first three bytes are stored; the fourth completes the word in flight.
    logic [WORD_W-9:0] shreg;
    logic [1:0]        idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg <= '0;
            idx   <= 2'd0;
        end else if (byte_en) begin
            shreg <= {shreg[WORD_W-17:0], byte_data};
            idx   <= idx + 2'd1;
        end
    end

    assign word_full = byte_en && (idx == 2'(BYTES_PER_WORD - 1));
    assign word      = {shreg, byte_data};

endmodule

// File: rtl/instruction_loader.sv
// Serial program loader: length byte, then N big-endian words written to instruction memory.
// Latency: mem_we pulses the cycle after the fourth byte; optional trailing checksum
// byte when INSTRUCTION_LOADER_CHECKSUM_EN is defined. Backpressure: byte_ready only while busy.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

    state_t            state;
    logic [7:0]        total;
    logic              xfer;
    logic              sess_start;
    logic              pack_en;
    logic              word_full;
    logic              last_word;
    logic [WORD_W-1:0] pack_word;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer       = byte_valid && byte_ready;
    assign sess_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign pack_en    = xfer && (state == ST_DATA);
    assign last_word  = (word_count == (total - 8'd1));

    loader_word_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (sess_start),
        .byte_en   (pack_en),
        .byte_data (byte_data),
        .word      (pack_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            total      <= 8'd0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= 8'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state      <= ST_LEN;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= 8'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        if (len_ok(byte_data, MEM_DEPTH)) begin
                            total <= byte_data;
                            state <= ST_DATA;
                        end else begin
                            state      <= ST_ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (word_full) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= ADDR_W'(word_count);
                            mem_wdata  <= pack_word;
                            word_count <= word_count + 8'd1;
                            if (last_word) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                                state <= ST_CHECK;
`else
                                state      <= ST_DONE;
                                byte_ready <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Words already written stay in memory whichever way this resolves.
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == csum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
